// File: rtl/risc_host_loader_if.sv
// risc_host_loader_if
//   Bundles every non-clock signal of risc_host_loader: the host load port,
//   the run/readback control, the readback stream, the my_risc external
//   memory-access port and the status outputs.
//   Modports:
//     master : the loader's view (receives I*, drives O*)
//     slave  : the host/core view (drives I*, receives O*)
//   Parameters: AW address width, DW data width.
interface risc_host_loader_if #(
    parameter int AW = 7,
    parameter int DW = 16
);
    // host load port
    logic          Ild_valid;
    logic [AW-1:0] Ild_addr;
    logic [DW-1:0] Ild_data;
    logic          Old_ready;
    // run control, readback window sampled with Igo
    logic          Igo;
    logic [AW-1:0] Irb_base;
    logic [AW:0]   Irb_count;
    // readback stream
    logic          Orb_valid;
    logic [AW-1:0] Orb_addr;
    logic [DW-1:0] Orb_data;
    logic          Irb_ready;
    // core memory-access port
    logic          Oaccess;
    logic          Owrb;
    logic [AW-1:0] Oaddr;
    logic [DW-1:0] Odata;
    logic          Ostart;
    logic [DW-1:0] Icpu_data;
    logic          Icpu_done;
    // status
    logic          Obusy;
    logic          Ofinish;
    logic          Otimeout;
    logic [15:0]   Ocycles;

    modport master (
        input  Ild_valid, Ild_addr, Ild_data, Igo, Irb_base, Irb_count,
               Irb_ready, Icpu_data, Icpu_done,
        output Old_ready, Orb_valid, Orb_addr, Orb_data, Oaccess, Owrb,
               Oaddr, Odata, Ostart, Obusy, Ofinish, Otimeout, Ocycles
    );

    modport slave (
        output Ild_valid, Ild_addr, Ild_data, Igo, Irb_base, Irb_count,
               Irb_ready, Icpu_data, Icpu_done,
        input  Old_ready, Orb_valid, Orb_addr, Orb_data, Oaccess, Owrb,
               Oaddr, Odata, Ostart, Obusy, Ofinish, Otimeout, Ocycles
    );
endinterface

// File: rtl/risc_host_loader.sv
// risc_host_loader
//   Host-side sequencer for the my_risc external memory-access port.
//   In IDLE it forwards host load words as single-cycle writes into the
//   core memory. Igo (with no load word pending) pulses start, waits for
//   the core's done level under a watchdog, then reads a window of memory
//   words back out as a valid/ready stream, and pulses Ofinish.
//   Ports:
//     Iclk    rising-edge clock
//     Ireset  synchronous active-low reset
//     bus     risc_host_loader_if.master (load port, readback stream,
//             core access port, status)
//   Parameters: AW, DW, TIMEOUT_CYCLES (max RUN cycles before abort).
module risc_host_loader #(
    parameter int AW             = 7,
    parameter int DW             = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                Iclk,
    input  logic                Ireset,
    risc_host_loader_if.master  bus
);
    // Watchdog counter is sized for TIMEOUT_CYCLES on its own so the abort
    // point stays exact even when Ocycles saturates below it.
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, START, RUN, RB_ADDR, RB_CAP, RB_OUT, DONE
    } state_t;

    state_t        state, state_nxt;

    // registered outputs
    logic          access, wrb, start, rb_valid, finish, busy, timeout;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [15:0]   cycles;

    // readback window and datapath
    logic [AW-1:0] base;
    logic [AW:0]   count, idx, idx_nxt;
    logic [DW-1:0] hold;
    logic [WDW-1:0] wdog;

    // next-cycle values of the core-side outputs
    logic          access_nxt, wrb_nxt, start_nxt;
    logic [AW-1:0] addr_nxt;
    logic [DW-1:0] data_nxt;

    logic          ld_ready, ld_acc, go_acc, rb_hs;
    logic          run_first, done_ok, wdog_hit, wdog_abort;

    // No load words are taken while reset is held.
    assign ld_ready = (state == IDLE) && Ireset;
    assign ld_acc   = ld_ready && bus.Ild_valid;
    // A load word in the same cycle wins over Igo.
    assign go_acc   = ld_ready && bus.Igo && !bus.Ild_valid;
    assign rb_hs    = (state == RB_OUT) && bus.Irb_ready;

    // wdog is cleared by Igo and counts RUN cycles, so zero marks the first
    // RUN cycle, where a done level left over from the previous run is
    // still possible and must not be trusted.
    assign run_first  = (wdog == '0);
    assign done_ok    = bus.Icpu_done && !run_first;
    assign wdog_hit   = (wdog == WDW'(TIMEOUT_CYCLES - 1));
    assign wdog_abort = (state == RUN) && !done_ok && wdog_hit;

    // ---------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------
    always_ff @(posedge Iclk) begin
        if (!Ireset) state <= IDLE;
        else         state <= state_nxt;
    end

    // ---------------------------------------------------------------
    // Next state and next core-side outputs
    // ---------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;

        case (state)
            IDLE: begin
                if (go_acc) begin
                    state_nxt = START;
                    idx_nxt   = '0;
                end
            end
            START:   state_nxt = RUN;
            RUN: begin
                if (done_ok)       state_nxt = (count == '0) ? DONE : RB_ADDR;
                else if (wdog_hit) state_nxt = DONE;
            end
            RB_ADDR: state_nxt = RB_CAP;
            RB_CAP:  state_nxt = RB_OUT;
            RB_OUT: begin
                if (rb_hs) begin
                    idx_nxt   = idx + (AW+1)'(1);
                    state_nxt = (idx_nxt == count) ? DONE : RB_ADDR;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Outputs are decided from the state being entered, then registered.
        access_nxt = 1'b1;
        wrb_nxt    = 1'b1;
        start_nxt  = 1'b0;
        addr_nxt   = addr;
        data_nxt   = data;

        case (state_nxt)
            IDLE: begin
                if (ld_acc) begin
                    wrb_nxt  = 1'b0;
                    addr_nxt = bus.Ild_addr;
                    data_nxt = bus.Ild_data;
                end
            end
            START: begin
                access_nxt = 1'b0;
                start_nxt  = 1'b1;
            end
            RUN:     access_nxt = 1'b0;
            // mod 2^AW wrap comes from the truncating AW-bit add
            RB_ADDR: addr_nxt = base + idx_nxt[AW-1:0];
            default: ;
        endcase
    end

    // ---------------------------------------------------------------
    // Output registers and datapath
    // ---------------------------------------------------------------
    always_ff @(posedge Iclk) begin
        if (!Ireset) begin
            access   <= 1'b1;
            wrb      <= 1'b1;
            addr     <= '0;
            data     <= '0;
            start    <= 1'b0;
            rb_valid <= 1'b0;
            finish   <= 1'b0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            cycles   <= '0;
            wdog     <= '0;
            base     <= '0;
            count    <= '0;
            idx      <= '0;
            hold     <= '0;
        end else begin
            access   <= access_nxt;
            wrb      <= wrb_nxt;
            addr     <= addr_nxt;
            data     <= data_nxt;
            start    <= start_nxt;
            rb_valid <= (state_nxt == RB_OUT);
            finish   <= (state_nxt == DONE);
            busy     <= (state_nxt != IDLE);
            idx      <= idx_nxt;

            if (go_acc) begin
                base    <= bus.Irb_base;
                count   <= bus.Irb_count;
                timeout <= 1'b0;
                cycles  <= '0;
                wdog    <= '0;
            end

            if (state == RUN) begin
                wdog <= wdog + WDW'(1);
                if (cycles != 16'hFFFF) cycles <= cycles + 16'd1;
            end

            if (wdog_abort) timeout <= 1'b1;

            // core read data arrives one cycle after the RB_ADDR request
            if (state == RB_CAP) hold <= bus.Icpu_data;
        end
    end

    assign bus.Old_ready = ld_ready;
    assign bus.Oaccess   = access;
    assign bus.Owrb      = wrb;
    assign bus.Oaddr     = addr;
    assign bus.Odata     = data;
    assign bus.Ostart    = start;
    assign bus.Orb_valid = rb_valid;
    assign bus.Orb_addr  = base + idx[AW-1:0];
    assign bus.Orb_data  = hold;
    assign bus.Obusy     = busy;
    assign bus.Ofinish   = finish;
    assign bus.Otimeout  = timeout;
    assign bus.Ocycles   = cycles;

endmodule

// File: tb/tb_risc_host_loader.sv
// tb_risc_host_loader
//   Bench for risc_host_loader with a behavioural stand-in for the my_risc
//   core: a 128-word memory with one-cycle read latency, and a run model
//   that raises done (level) a configurable number of cycles after start.
//   The done level is only dropped one cycle after start, so a stale done
//   is visible in the first RUN cycle. In "divide" mode the core writes
//   mem[66] = mem[65] / mem[64] when it finishes.
module tb_risc_host_loader;
    localparam int AW  = 7;
    localparam int DW  = 16;
    localparam int TMO = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    risc_host_loader_if #(.AW(AW), .DW(DW)) bus ();

    risc_host_loader #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .Iclk   (clk),
        .Ireset (rst),
        .bus    (bus.master)
    );

    // ---------------- core stand-in ----------------
    logic [15:0] core_mem [128];
    int          run_len_cfg;   // 0 = never finishes
    bit          div_cfg;
    int          run_cnt;
    bit          running, clr_pend;

    always @(posedge clk) begin
        if (bus.Oaccess && !bus.Owrb) core_mem[bus.Oaddr] <= bus.Odata;
        if (bus.Oaccess &&  bus.Owrb) bus.Icpu_data <= core_mem[bus.Oaddr];
        if (!rst) begin
            bus.Icpu_done <= 1'b0;
            running       <= 1'b0;
            clr_pend      <= 1'b0;
            run_cnt       <= 0;
        end else begin
            if (clr_pend) begin
                bus.Icpu_done <= 1'b0;
                clr_pend      <= 1'b0;
            end
            if (bus.Ostart) begin
                clr_pend <= 1'b1;
                run_cnt  <= 1;
                running  <= 1'b1;
            end else if (running) begin
                if (run_len_cfg != 0 && run_cnt == run_len_cfg) begin
                    bus.Icpu_done <= 1'b1;
                    running       <= 1'b0;
                    if (div_cfg) core_mem[66] <= core_mem[65] / core_mem[64];
                end else begin
                    run_cnt <= run_cnt + 1;
                end
            end
        end
    end

    // ---------------- reference state ----------------
    logic [15:0] ref_mem [128];
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge; leaves the bench at the negedge of the write cycle.
    task automatic load_word(input logic [6:0] a, input logic [15:0] d);
        bus.Ild_valid = 1'b1;
        bus.Ild_addr  = a;
        bus.Ild_data  = d;
        chk("ld_ready", 64'(bus.Old_ready), 64'd1);
        tick();
        bus.Ild_valid = 1'b0;
        ref_mem[a] = d;
        chk("load_write", 64'({bus.Oaccess, bus.Owrb, bus.Oaddr, bus.Odata}),
            64'({1'b1, 1'b0, a, d}));
    endtask

    // What a run must produce, from the rules: done becomes visible one
    // cycle after the core's run length, the watchdog caps RUN at TMO cycles.
    function automatic void model_run(input int rl, input int cnt,
                                      output bit to, output int cyc, output int nw);
        to  = (rl == 0) || (rl + 1 > TMO);
        cyc = to ? TMO : rl + 1;
        nw  = to ? 0 : cnt;
    endfunction

    task automatic run_case(input logic [6:0] base, input int count, input int rl,
                            input bit div, input int bp, input bit rnd,
                            output int nw, output bit to, output int cyc,
                            output logic [2:0][15:0] got);
        logic [6:0]  ea [$];
        logic [15:0] ed [$];
        bit          e_to;
        int          e_cyc, e_nw, t, first_t, fin_t, nvalid;
        bit          hold;
        logic [6:0]  ha;
        logic [15:0] hd;
        logic [6:0]  wa;
        logic [15:0] wd;

        model_run(rl, count, e_to, e_cyc, e_nw);
        if (div) ref_mem[66] = ref_mem[65] / ref_mem[64];
        for (int k = 0; k < e_nw; k++) begin
            wa = 7'(int'(base) + k);
            ea.push_back(wa);
            ed.push_back(ref_mem[wa]);
        end

        run_len_cfg   = rl;
        div_cfg       = div;
        bus.Irb_base  = base;
        bus.Irb_count = 8'(count);
        bus.Igo       = 1'b1;
        tick();
        bus.Igo = 1'b0;
        chk("start_cycle", 64'({bus.Ostart, bus.Oaccess, bus.Old_ready, bus.Obusy}), 64'(4'b1001));

        nw = 0; t = 0; first_t = -1; fin_t = -1; nvalid = 0; hold = 1'b0;
        got = '0; ha = '0; hd = '0;
        while (fin_t < 0 && t < 3000) begin
            if (hold) chk("rb_valid_held", 64'(bus.Orb_valid), 64'd1);
            if (bus.Orb_valid) begin
                if (first_t < 0) first_t = t;
                if (hold) chk("rb_stable", 64'({bus.Orb_addr, bus.Orb_data}), 64'({ha, hd}));
                bus.Irb_ready = (nvalid < bp) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
                nvalid++;
                if (bus.Irb_ready) begin
                    if (ea.size() == 0) begin
                        chk("rb_extra_word", 64'(nw + 1), 64'(e_nw));
                    end else begin
                        wa = ea.pop_front();
                        wd = ed.pop_front();
                        chk("rb_word", 64'({bus.Orb_addr, bus.Orb_data}), 64'({wa, wd}));
                    end
                    if (nw < 3) got[nw] = bus.Orb_data;
                    nw++;
                    hold = 1'b0;
                end else begin
                    hold = 1'b1;
                    ha   = bus.Orb_addr;
                    hd   = bus.Orb_data;
                end
            end else begin
                hold = 1'b0;
                bus.Irb_ready = 1'($urandom_range(0, 1));
            end
            if (bus.Ofinish) fin_t = t;
            tick();
            t++;
        end
        bus.Irb_ready = 1'b0;

        if (fin_t < 0) begin
            n_chk++;
            n_err++;
            $display("FAIL finish_seen: got no Ofinish after %0d cycles, want one pulse", t);
        end
        chk("finish_pulse_end", 64'({bus.Ofinish, bus.Obusy}), 64'd0);
        if (e_nw > 0) chk("first_valid_latency", 64'(first_t), 64'(rl + 4));
        else          chk("finish_latency", 64'(fin_t), 64'(e_to ? TMO + 1 : rl + 2));
        to  = bus.Otimeout;
        cyc = int'(bus.Ocycles);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [6:0]       base;
        int               count;
        int               rl;
        bit               div;
        int               bp;
        bit               rnd;
        int               npre;
        logic [6:0]       pa0, pa1;
        logic [15:0]      pd0, pd1;
        bit               exp_to;
        int               exp_cyc;
        int               exp_nw;
        logic [2:0][15:0] exp_w;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int               nw, cyc, nl, cnt, rl, e_cyc, e_nw, vis;
        bit               to, e_to;
        logic [2:0][15:0] got;
        logic [6:0]       base;

        // division: 12/3 written to mem[66], window 64..66
        vecs[0] = '{base:7'd64, count:3, rl:20, div:1'b1, bp:0, rnd:1'b0, npre:0,
                    pa0:7'd0, pa1:7'd0, pd0:16'd0, pd1:16'd0,
                    exp_to:1'b0, exp_cyc:21, exp_nw:3, exp_w:{16'd4, 16'd12, 16'd3}};
        // watchdog: JMP self never finishes
        vecs[1] = '{base:7'd0, count:3, rl:0, div:1'b0, bp:0, rnd:1'b0, npre:1,
                    pa0:7'd0, pa1:7'd0, pd0:16'h9000, pd1:16'd0,
                    exp_to:1'b1, exp_cyc:64, exp_nw:0, exp_w:'0};
        // wrap 127 -> 0 with 5 cycles of backpressure on the first word
        vecs[2] = '{base:7'd127, count:2, rl:6, div:1'b0, bp:5, rnd:1'b0, npre:2,
                    pa0:7'd127, pa1:7'd0, pd0:16'hAAAA, pd1:16'h0001,
                    exp_to:1'b0, exp_cyc:7, exp_nw:2, exp_w:{16'd0, 16'h0001, 16'hAAAA}};
        // zero count: straight to DONE
        vecs[3] = '{base:7'd0, count:0, rl:4, div:1'b0, bp:0, rnd:1'b0, npre:1,
                    pa0:7'd0, pa1:7'd0, pd0:16'h0001, pd1:16'd0,
                    exp_to:1'b0, exp_cyc:5, exp_nw:0, exp_w:'0};
        // whole memory once
        vecs[4] = '{base:7'd10, count:128, rl:3, div:1'b0, bp:0, rnd:1'b1, npre:0,
                    pa0:7'd0, pa1:7'd0, pd0:16'd0, pd1:16'd0,
                    exp_to:1'b0, exp_cyc:4, exp_nw:128, exp_w:'0};

        bus.Ild_valid = 1'b0; bus.Ild_addr = '0; bus.Ild_data = '0;
        bus.Igo = 1'b0; bus.Irb_base = '0; bus.Irb_count = '0; bus.Irb_ready = 1'b0;
        run_len_cfg = 0; div_cfg = 1'b0;

        // reset state, sampled while reset is still held
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_core_port", 64'({bus.Oaccess, bus.Owrb, bus.Oaddr, bus.Odata, bus.Ostart}),
            64'({1'b1, 1'b1, 7'd0, 16'd0, 1'b0}));
        chk("reset_ld_ready", 64'(bus.Old_ready), 64'd0);
        chk("reset_status", 64'({bus.Orb_valid, bus.Ofinish, bus.Otimeout, bus.Ocycles, bus.Obusy}), 64'd0);
        rst = 1'b1;
        tick();
        chk("ready_after_reset", 64'({bus.Old_ready, bus.Oaccess, bus.Owrb}), 64'(3'b111));

        // fill the whole memory back-to-back, then the program image
        for (int a = 0; a < 128; a++) load_word(7'(a), 16'($urandom));
        for (int i = 0; i < 26; i++) load_word(7'(i), 16'(16'h1000 + i));
        load_word(7'd64, 16'd3);
        load_word(7'd65, 16'd12);
        tick();
        chk("idle_harmless_read", 64'({bus.Oaccess, bus.Owrb, bus.Obusy}), 64'(3'b110));

        for (int v = 0; v < 5; v++) begin
            if (vecs[v].npre > 0) load_word(vecs[v].pa0, vecs[v].pd0);
            if (vecs[v].npre > 1) load_word(vecs[v].pa1, vecs[v].pd1);
            tick();
            run_case(vecs[v].base, vecs[v].count, vecs[v].rl, vecs[v].div, vecs[v].bp,
                     vecs[v].rnd, nw, to, cyc, got);
            chk($sformatf("vec%0d_timeout", v), 64'(to), 64'(vecs[v].exp_to));
            chk($sformatf("vec%0d_cycles", v), 64'(cyc), 64'(vecs[v].exp_cyc));
            chk($sformatf("vec%0d_words", v), 64'(nw), 64'(vecs[v].exp_nw));
            for (int k = 0; k < 3 && k < vecs[v].exp_nw && v < 4; k++)
                chk($sformatf("vec%0d_data%0d", v, k), 64'(got[k]), 64'(vecs[v].exp_w[k]));
        end

        // Igo together with a load word: the write wins, no run starts
        bus.Ild_valid = 1'b1; bus.Ild_addr = 7'd5; bus.Ild_data = 16'h1234;
        bus.Igo = 1'b1; bus.Irb_count = 8'd3;
        tick();
        bus.Ild_valid = 1'b0; bus.Igo = 1'b0;
        ref_mem[5] = 16'h1234;
        chk("collision_write", 64'({bus.Oaccess, bus.Owrb, bus.Oaddr, bus.Odata, bus.Ostart, bus.Obusy}),
            64'({1'b1, 1'b0, 7'd5, 16'h1234, 1'b0, 1'b0}));
        tick();
        chk("collision_idle", 64'({bus.Ostart, bus.Obusy, bus.Oaccess, bus.Owrb}), 64'(4'b0011));

        // reset for one cycle in the middle of RUN
        run_len_cfg = 0;
        bus.Irb_base = 7'd0; bus.Irb_count = 8'd2; bus.Igo = 1'b1;
        tick();
        bus.Igo = 1'b0;
        repeat (10) tick();
        chk("midrun_busy", 64'({bus.Obusy, bus.Oaccess}), 64'(2'b10));
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("reset_midrun", 64'({bus.Oaccess, bus.Ostart, bus.Ocycles, bus.Obusy,
                                 bus.Orb_valid, bus.Ofinish, bus.Otimeout}),
            64'({1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0}));
        vis = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.Orb_valid || bus.Ofinish || bus.Obusy) vis++;
        end
        chk("after_reset_quiet", 64'(vis), 64'd0);

        // randomized runs against the model
        for (int it = 0; it < 15; it++) begin
            nl = $urandom_range(0, 5);
            for (int j = 0; j < nl; j++) begin
                if ($urandom_range(0, 1) == 1) tick();
                load_word(7'($urandom_range(0, 127)), 16'($urandom));
            end
            tick();
            base = 7'($urandom_range(0, 127));
            cnt  = $urandom_range(0, 6);
            rl   = $urandom_range(2, 70);
            if (rl == TMO - 1) rl = TMO - 2;
            model_run(rl, cnt, e_to, e_cyc, e_nw);
            run_case(base, cnt, rl, 1'b0, $urandom_range(0, 2), 1'b1, nw, to, cyc, got);
            chk($sformatf("rand%0d_timeout", it), 64'(to), 64'(e_to));
            chk($sformatf("rand%0d_cycles", it), 64'(cyc), 64'(e_cyc));
            chk($sformatf("rand%0d_words", it), 64'(nw), 64'(e_nw));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/risc_host_loader.md
# risc_host_loader

Host-side controller for the `my_risc` external memory-access port. It writes a program and data image into the core's 128-word memory, then pulses start. It waits for done, with a watchdog. It then reads a window of result words back out as a valid/ready stream. It replaces the hand-sequenced access/write/start/readback stimulus with synthesizable logic, and sits between a host word source and the core.

## Interface
- `AW`, 7, memory address width (128 words)
- `DW`, 16, data word width
- `TIMEOUT_CYCLES`, 4096, maximum RUN cycles before abort

- `Iclk`  in  1  clock, rising edge
- `Ireset`  in  1  synchronous, active-low reset
- `Ild_valid`  in  1  load word valid
- `Ild_addr`  in  AW  load word address
- `Ild_data`  in  DW  load word data
- `Old_ready`  out  1  load word accepted when valid&ready
- `Igo`  in  1  end load phase and run the program
- `Irb_base`  in  AW  first readback address, sampled with `Igo`
- `Irb_count`  in  AW+1  number of words to read back (0..128), sampled with `Igo`
- `Orb_valid`  out  1  readback word valid
- `Orb_addr`  out  AW  address of the readback word
- `Orb_data`  out  DW  readback word
- `Irb_ready`  in  1  readback word consumed when valid&ready
- `Oaccess`  out  1  to core: external memory access enable
- `Owrb`  out  1  to core: 0 = write, 1 = read
- `Oaddr`  out  AW  to core: access address
- `Odata`  out  DW  to core: write data
- `Ostart`  out  1  to core: start pulse
- `Icpu_data`  in  DW  from core: memory read data
- `Icpu_done`  in  1  from core: program halted (level)
- `Obusy`  out  1  high in every state except IDLE
- `Ofinish`  out  1  one-cycle pulse at end of sequence
- `Otimeout`  out  1  sticky: last run hit the watchdog; cleared by the next `Igo`
- `Ocycles`  out  16  RUN cycles of the last run, saturating at 16'hFFFF

## Operation
- States: IDLE, START, RUN, RB_ADDR, RB_CAP, RB_OUT, DONE.
- All core-side outputs are registered.
- **IDLE**
  - `Old_ready=1`.
  - An accepted word drives `Oaccess=1`, `Owrb=0`, `Oaddr=Ild_addr`, `Odata=Ild_data` for exactly the next cycle.
  - Otherwise `Oaccess=1`, `Owrb=1` (a harmless read).
  - Back-to-back acceptance gives one write per cycle.
- **Igo in IDLE**
  - Honoured only when `Ild_valid=0`; if `Ild_valid=1` in the same cycle, the load word is accepted and `Igo` is ignored.
  - `Igo` latches base and count, clears `Otimeout` and `Ocycles`, and moves to START.
- **START** (one cycle): `Oaccess=0`, `Owrb=1`, `Ostart=1`, `Old_ready=0`.
- **RUN**
  - `Oaccess=0`, `Ostart=0`; `Ocycles` increments each cycle.
  - `Icpu_done` is ignored in the START cycle and the first RUN cycle, because it may be stale from the previous run.
  - `Icpu_done=1` goes to RB_ADDR, or to DONE if count=0.
  - `Ocycles` reaching `TIMEOUT_CYCLES` sets `Otimeout` and goes to DONE with no readback.
- **RB_ADDR**: `Oaccess=1`, `Owrb=1`, `Oaddr=(base+i) mod 2^AW`.
- **RB_CAP**: capture `Icpu_data` (read latency one cycle) into the hold register, then go to RB_OUT.
- **RB_OUT**
  - `Orb_valid=1`; data and address are held stable until `Irb_ready`.
  - On handshake, i++; if i==count go to DONE, else go to RB_ADDR.
- **DONE**: `Ofinish=1` for one cycle, `Oaccess=1`, `Owrb=1`, then IDLE.

## Timing
- Reset (`Ireset=0` at a rising edge):
  - State IDLE.
  - `Oaccess=1`, `Owrb=1`, `Oaddr=0`, `Odata=0`.
  - `Ostart=0`, `Old_ready=0` during the reset cycle, then 1.
  - `Orb_valid=0`, `Ofinish=0`, `Otimeout=0`, `Ocycles=0`, `Obusy=0`.
- Reset in any state aborts immediately; no partial readback word is emitted afterwards.
- Load write: word accepted at edge T; write visible on the core port during cycle T+1.
- `Igo` accepted at edge T: `Ostart=1` during T+1; RUN from T+2.
- Done seen at edge D: `Oaddr` presented at D+1; `Orb_valid` rises at D+3.
- Each further word costs 3 cycles plus backpressure.
- Address wraps: base=127, count=2 reads 127 then 0.
- count=128 reads the whole memory once.
- `Ocycles` saturates and never wraps.
- Inputs `Ild_*` and `Igo` are ignored outside IDLE.

## Test plan
- Division program: load mem[64]=3, mem[65]=12 and the 26-word divide program at 0..25, then `Igo` with base=64, count=3. Required: stream 3, 12, 4, `Ofinish` pulse, `Otimeout=0`.
- Watchdog: mem[0]=16'h9000 (JMP self), `TIMEOUT_CYCLES=64`. Required: `Otimeout=1`, `Ocycles=64`, no `Orb_valid`, `Ofinish` pulse.
- Wrap and backpressure: preload mem[127]=16'hAAAA, mem[0]=HALT, base=127, count=2, `Irb_ready` low for 5 cycles. Required: `Orb_data` held at 16'hAAAA at addr 127, then 16'h0001 at addr 0.
- Zero count: HALT at 0, count=0. Required: DONE reached directly after done, no `Orb_valid`.
- `Igo` collision: `Igo` and `Ild_valid` high together. Required: the write occurs, state stays IDLE, `Ostart` stays 0.
- Reset mid-RUN: drop `Ireset` for one cycle during RUN. Required: next cycle IDLE, `Oaccess=1`, `Ostart=0`, `Ocycles=0`, `Obusy=0`.
